pwm_dac_multi: RTL and testbench

Multi-channel audio DAC output stage: the parametrised successor to the single-pin PWM audio output used on the iceFUN build. It accepts one packed sample word for all channels via a valid/ready handshake and double-buffers it. The buffered word is applied glitch-free at the PWM period boundary. Each channel is driven as either classic PWM or first-order sigma-delta, selected by parameter. It sits between the music/sample generator and the board audio pins.

---
 rtl/pwm_dac_multi.sv | 104 ++++++++++
 tb/tb_pwm_dac_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac_multi.sv
// Multi-channel audio DAC output stage: a double-buffered sample word drives one
// PWM or first-order sigma-delta modulator per channel, updated at period boundaries.
`timescale 1ns/1ps
module pwm_dac_multi #(
   parameter int CHANNELS = 2,
   parameter int SAMPLE_W = 10,
   parameter int MODE     = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
   input  logic                         sample_valid,
   output logic                         sample_ready,
   output logic [CHANNELS-1:0]          pwm,
   output logic                         period_strobe,
   output logic                         underrun
);

   localparam int                  WORD_W  = CHANNELS * SAMPLE_W;
   localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;
   localparam logic [SAMPLE_W-1:0] CNT_PRE = {{(SAMPLE_W-1){1'b1}}, 1'b0};

   logic [SAMPLE_W-1:0] cnt;
   logic [WORD_W-1:0]   stage;
   logic [WORD_W-1:0]   active;
   logic                stage_full;
   logic                stage_full_nxt;
   logic                boundary;
   logic                accept;

   assign boundary     = enable && (cnt == CNT_MAX);
   assign accept       = sample_valid && !stage_full;
   assign sample_ready = !stage_full;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      stage_full_nxt = stage_full;
      if (boundary && stage_full)
         stage_full_nxt = 1'b0;
      else if (accept)
         stage_full_nxt = 1'b1;
   end

   // Strobe and underrun are predicted one cycle early so both land in the cnt==MAX cycle.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= '0;
         stage         <= '0;
         active        <= '0;
         stage_full    <= 1'b0;
         period_strobe <= 1'b0;
         underrun      <= 1'b0;
      end else begin
         cnt           <= enable ? cnt + SAMPLE_W'(1) : '0;
         stage_full    <= stage_full_nxt;
         period_strobe <= enable && (cnt == CNT_PRE);
         underrun      <= enable && (cnt == CNT_PRE) && !stage_full_nxt;
         if (accept)
            stage <= sample_data;
         if (boundary && stage_full)
            active <= stage;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SAMPLE_W-1:0] level;
      logic                pwm_q;

      assign level  = active[i*SAMPLE_W +: SAMPLE_W];
      assign pwm[i] = pwm_q;

      if (MODE == 0) begin : g_pwm
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               pwm_q <= 1'b0;
            else
               pwm_q <= enable && (cnt < level);
         end
      end else begin : g_sd
         // Only the low bits persist; the carry of each sum is the output bit.
         logic [SAMPLE_W-1:0] acc;
         logic [SAMPLE_W:0]   sum;

         assign sum = {1'b0, acc} + {1'b0, level};

         // NOTE: the accumulator is reset explicitly; an unknown start value would skew the first period's duty.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               acc   <= '0;
               pwm_q <= 1'b0;
            end else if (!enable) begin
               acc   <= '0;
               pwm_q <= 1'b0;
            end else begin
               acc   <= sum[SAMPLE_W-1:0];
               pwm_q <= sum[SAMPLE_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Directed bench for pwm_dac_multi: a PWM instance and a sigma-delta instance,
// both 2 channels x 4 bits, checked against hand-computed duty and timing values.
`timescale 1ns/1ps
module tb_pwm_dac_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic       en0, valid0, ready0, strobe0, ur0;
   logic [7:0] data0;
   logic [1:0] pwm0;
   logic       en1, valid1, ready1, strobe1, ur1;
   logic [7:0] data1;
   logic [1:0] pwm1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pwm_dac_multi #(.CHANNELS(2), .SAMPLE_W(4), .MODE(0)) u_pwm (
      .clk(clk), .rst(rst), .enable(en0), .sample_data(data0), .sample_valid(valid0),
      .sample_ready(ready0), .pwm(pwm0), .period_strobe(strobe0), .underrun(ur0));

   pwm_dac_multi #(.CHANNELS(2), .SAMPLE_W(4), .MODE(1)) u_sd (
      .clk(clk), .rst(rst), .enable(en1), .sample_data(data1), .sample_valid(valid1),
      .sample_ready(ready1), .pwm(pwm1), .period_strobe(strobe1), .underrun(ur1));

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; the source drops valid once its word has been taken.
   task automatic tick();
      bit a0, a1;
      a0 = valid0 && ready0;
      a1 = valid1 && ready1;
      @(posedge clk);
      #1;
      if (a0) valid0 = 1'b0;
      if (a1) valid1 = 1'b0;
   endtask

   task automatic wait_strobe0(input string tag);
      int n = 0;
      while (!strobe0 && n < 40) begin
         tick();
         n++;
      end
      check(tag, int'(strobe0), 1);
   endtask

   task automatic wait_strobe1(input string tag);
      int n = 0;
      while (!strobe1 && n < 40) begin
         tick();
         n++;
      end
      check(tag, int'(strobe1), 1);
   endtask

   // Entered in a strobe cycle (or at cnt=0 when first=1); samples cycles cnt=first..15.
   // Channel 0 must be high exactly for cnt=1..v; strobe only at cnt=15.
   task automatic measure0(input string tag, input int v, input int first, input int exp_ur);
      int hi0 = 0, hi1 = 0, shape_err = 0, st = 0, ur = 0, ur_mis = 0;
      bit exp_bit;
      for (int i = first; i < 16; i++) begin
         tick();
         exp_bit = (i >= 1) && (i <= v);
         if (pwm0[0] !== exp_bit) shape_err++;
         hi0 += int'(pwm0[0]);
         hi1 += int'(pwm0[1]);
         st  += int'(strobe0);
         ur  += int'(ur0);
         if (ur0 && !strobe0) ur_mis++;
      end
      check({tag, "_high0"}, hi0, v);
      check({tag, "_shape0"}, shape_err, 0);
      check({tag, "_high1"}, hi1, 0);
      check({tag, "_strobes"}, st, 1);
      check({tag, "_strobe_last"}, int'(strobe0), 1);
      check({tag, "_underrun"}, ur, exp_ur);
      check({tag, "_ur_align"}, ur_mis, 0);
   endtask

   // Stage v into the sigma-delta instance, let it reach active, then count 64 cycles.
   task automatic sd_run(input string tag, input int v);
      bit s [64];
      int hi = 0, hi1 = 0, alt_err = 0, per_err = 0;
      wait_strobe1({tag, "_strobe_a"});
      valid1 = 1'b1;
      data1  = 8'(v);
      tick();
      check({tag, "_staged"}, int'(ready1), 0);
      wait_strobe1({tag, "_strobe_b"});
      tick();
      for (int k = 0; k < 64; k++) begin
         tick();
         s[k] = pwm1[0];
         hi  += int'(pwm1[0]);
         hi1 += int'(pwm1[1]);
      end
      check({tag, "_high64"}, hi, 4 * v);
      check({tag, "_high1"}, hi1, 0);
      if (v == 8) begin
         for (int k = 1; k < 64; k++)
            if (s[k] == s[k-1]) alt_err++;
         check({tag, "_alternate"}, alt_err, 0);
      end
      if (v == 1) begin
         for (int k = 16; k < 64; k++)
            if (s[k] != s[k-16]) per_err++;
         check({tag, "_period16"}, per_err, 0);
      end
   endtask

   initial begin
      int cnt_hi, cnt_st, cnt_ur, cnt_rdy;
      rst    = 1'b1;
      en0    = 1'b0;
      en1    = 1'b0;
      valid0 = 1'b0;
      valid1 = 1'b0;
      data0  = 8'h00;
      data1  = 8'h00;

      // Reset state
      #12;
      check("rst_ready0", int'(ready0), 1);
      check("rst_pwm0", int'(pwm0), 0);
      check("rst_strobe0", int'(strobe0), 0);
      check("rst_underrun0", int'(ur0), 0);
      check("rst_ready1", int'(ready1), 1);
      check("rst_pwm1", int'(pwm1), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic PWM: ch0=5, ch1=0 staged before the first boundary
      data0  = 8'h05;
      valid0 = 1'b1;
      tick();
      check("t1_ready_low", int'(ready0), 0);
      check("t1_idle_strobe", int'(strobe0), 0);
      en0 = 1'b1;
      wait_strobe0("t1_first_strobe");
      check("t1_first_underrun", int'(ur0), 0);
      measure0("t1_p5", 5, 0, 1);

      // Back-pressure: 0x3 taken at the boundary, 0x9 held until the next one
      valid0 = 1'b1;
      data0  = 8'h03;
      tick();
      check("t2_ready_after_3", int'(ready0), 0);
      valid0 = 1'b1;
      data0  = 8'h09;
      cnt_rdy = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         cnt_rdy += int'(ready0);
      end
      check("t2_ready_held_low", cnt_rdy, 0);
      check("t2_strobe", int'(strobe0), 1);
      check("t2_no_underrun", int'(ur0), 0);
      measure0("t2_p3", 3, 0, 0);
      check("t2_nine_staged", int'(ready0), 0);
      measure0("t2_p9", 9, 0, 1);

      // Underrun: one sample of 7, then nothing
      valid0 = 1'b1;
      data0  = 8'h07;
      measure0("t3_p9", 9, 0, 0);
      measure0("t3_p7a", 7, 0, 1);
      measure0("t3_p7b", 7, 0, 1);

      // Enable dropped mid-period for 10 cycles with a sample offered meanwhile
      for (int i = 0; i < 5; i++) tick();
      check("t5_pre_pwm", int'(pwm0[0]), 1);
      en0    = 1'b0;
      valid0 = 1'b1;
      data0  = 8'h02;
      cnt_hi = 0;
      cnt_st = 0;
      cnt_ur = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt_hi += int'(pwm0 != 2'b00);
         cnt_st += int'(strobe0);
         cnt_ur += int'(ur0);
      end
      check("t5_pwm_idle", cnt_hi, 0);
      check("t5_no_strobe", cnt_st, 0);
      check("t5_no_underrun", cnt_ur, 0);
      check("t5_staged", int'(ready0), 0);
      en0 = 1'b1;
      measure0("t5_reen", 7, 1, 0);
      measure0("t5_applied", 2, 0, 1);

      // Asynchronous reset mid-period with a staged word
      valid0 = 1'b1;
      data0  = 8'h0B;
      tick();
      check("t6_staged", int'(ready0), 0);
      tick();
      tick();
      check("t6_pre_pwm", int'(pwm0[0]), 1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_pwm", int'(pwm0), 0);
      check("t6_async_ready", int'(ready0), 1);
      check("t6_async_strobe", int'(strobe0), 0);
      check("t6_async_underrun", int'(ur0), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_strobe0("t6_strobe");
      check("t6_underrun", int'(ur0), 1);
      measure0("t6_discard", 0, 0, 1);

      // Sigma-delta instance
      check("t4_idle_pwm", int'(pwm1), 0);
      en1 = 1'b1;
      sd_run("t4_v8", 8);
      sd_run("t4_v1", 1);
      sd_run("t4_v0", 0);
      sd_run("t4_v15", 15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
